shifter_pipe: RTL and testbench

- Parametrised, pipelined barrel shifter with a valid/ready stream interface.
- Successor to the 16-bit combinational shifter: any power-of-two width, rotate modes added, one register stage per shift bit.
- Sits between the decode/issue stage and writeback in the NPC execute path. Serves SLL/SRL/SRA and rotate ops, and meets timing at wide DWIDTH.

---
 rtl/shifter_pipe.sv | 140 ++++++++++++++
 tb/tb_shifter_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SRL/SLL/SRA/ROR/ROL/pass) with valid/ready handshake; one stage per shift-amount bit.
// Optional SHIFTER_ZERO_FLAG_EN adds a registered out_zero flag aligned with out_data.
module shifter_pipe #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned SHIFT_NUM = $clog2(DWIDTH),
  parameter int unsigned TAG_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DWIDTH-1:0]    in_data,
  input  logic [SHIFT_NUM-1:0] in_shamt,
  input  logic [2:0]           in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DWIDTH-1:0]    out_data,
  output logic [TAG_W-1:0]     out_tag
`ifdef SHIFTER_ZERO_FLAG_EN
  ,
  output logic                 out_zero
`endif
);

  localparam int unsigned LAST   = SHIFT_NUM - 1;
  localparam int unsigned MODE_W = 3;

  logic                 r_valid [SHIFT_NUM];
  logic [DWIDTH-1:0]    r_data  [SHIFT_NUM];
  logic [TAG_W-1:0]     r_tag   [SHIFT_NUM];
  // Control only needs to reach the stage before the last one.
  logic [SHIFT_NUM-1:0] r_shamt [LAST];
  logic [MODE_W-1:0]    r_mode  [LAST];
  logic                 r_sign  [LAST];

  logic w_adv;

  assign w_adv     = !r_valid[LAST] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_valid[LAST];
  assign out_data  = r_data[LAST];
  assign out_tag   = r_tag[LAST];

`ifdef SHIFTER_ZERO_FLAG_EN
  logic r_zero;
  assign out_zero = r_zero;
`endif

  for (genvar k = 0; k < SHIFT_NUM; k++) begin : g_stage
    localparam int unsigned AMT = 2 ** k;

    logic              w_vld;
    logic [DWIDTH-1:0] w_d;
    logic              w_bit;
    logic [MODE_W-1:0] w_md;
    logic              w_sg;
    logic [TAG_W-1:0]  w_tg;
    logic [DWIDTH-1:0] w_res;

    if (k == 0) begin : g_src
      // Sign captured once here so later SRA stages fill with the original MSB.
      assign w_vld = in_valid;
      assign w_d   = in_data;
      assign w_bit = in_shamt[0];
      assign w_md  = in_mode;
      assign w_sg  = in_data[DWIDTH-1];
      assign w_tg  = in_tag;
    end else begin : g_src
      assign w_vld = r_valid[k-1];
      assign w_d   = r_data[k-1];
      assign w_bit = r_shamt[k-1][0];
      assign w_md  = r_mode[k-1];
      assign w_sg  = r_sign[k-1];
      assign w_tg  = r_tag[k-1];
    end

    // Conditional shift/rotate by 2^k.
    always_comb begin
      w_res = w_d;
      if (w_bit) begin
        case (w_md)
          3'b000:         w_res = w_d >> AMT;
          3'b001, 3'b011: w_res = w_d << AMT;
          3'b010:         w_res = (w_d >> AMT) | ({DWIDTH{w_sg}} << (DWIDTH - AMT));
          3'b100:         w_res = (w_d >> AMT) | (w_d << (DWIDTH - AMT));
          3'b101:         w_res = (w_d << AMT) | (w_d >> (DWIDTH - AMT));
          default:        w_res = w_d;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_tag[k]   <= '0;
      end else if (w_adv) begin
        r_valid[k] <= w_vld;
        r_data[k]  <= w_res;
        r_tag[k]   <= w_tg;
      end
    end

    if (k < LAST) begin : g_ctrl
      // Remaining shamt is shifted down so the next stage always reads bit 0.
      logic [SHIFT_NUM-1:0] w_sh_full;
      if (k == 0) begin : g_sh
        assign w_sh_full = in_shamt;
      end else begin : g_sh
        assign w_sh_full = r_shamt[k-1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_shamt[k] <= '0;
          r_mode[k]  <= '0;
          r_sign[k]  <= 1'b0;
        end else if (w_adv) begin
          r_shamt[k] <= w_sh_full >> 1;
          r_mode[k]  <= w_md;
          r_sign[k]  <= w_sg;
        end
      end
    end

`ifdef SHIFTER_ZERO_FLAG_EN
    if (k == LAST) begin : g_zero
      always_ff @(posedge clk) begin
        if (rst) begin
          r_zero <= 1'b0;
        end else if (w_adv) begin
          r_zero <= (w_res == '0);
        end
      end
    end
`endif
  end

endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe (DWIDTH=16): directed test-plan cases plus randomized traffic against a queue-based reference model.
module tb_shifter_pipe;

  localparam int unsigned DW = 16;
  localparam int unsigned SN = 4;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [SN-1:0] in_shamt;
  logic [2:0]    in_mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
`ifdef SHIFTER_ZERO_FLAG_EN
  logic          out_zero;
`endif

  always #5 clk = ~clk;

  shifter_pipe #(.DWIDTH(DW), .SHIFT_NUM(SN), .TAG_W(TW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef SHIFTER_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    int            c;
  } exp_t;

  exp_t          q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  bit            lat_mode = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] hold_d;
  logic [TW-1:0] hold_t;
  logic          hold_z;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole-amount reference: direct arithmetic on the full shift amount.
  function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] d, input logic [SN-1:0] sh,
                                              input logic [2:0] m);
    logic signed [DW-1:0] s;
    s = d;
    case (m)
      3'd0:       return d >> sh;
      3'd1, 3'd3: return d << sh;
      3'd2:       return DW'(s >>> sh);
      3'd4:       return (d >> sh) | (d << (DW - 32'(sh)));
      3'd5:       return (d << sh) | (d >> (DW - 32'(sh)));
      default:    return d;
    endcase
  endfunction

  task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic [SN-1:0] sh,
                       input logic [2:0] m, input logic [TW-1:0] t, input logic ordy, input logic rv);
    exp_t e;
    @(negedge clk);
    rst = rv; in_valid = iv; in_data = d; in_shamt = sh; in_mode = m; in_tag = t; out_ready = ordy;
    #1;
    check_eq("in_ready", 32'(in_ready), 32'(!out_valid || ordy));
    if (stall_prev) begin
      check_eq("stall_data", 32'(out_data), 32'(hold_d));
      check_eq("stall_tag", 32'(out_tag), 32'(hold_t));
`ifdef SHIFTER_ZERO_FLAG_EN
      check_eq("stall_zero", 32'(out_zero), 32'(hold_z));
`endif
    end
    stall_prev = out_valid && !ordy && !rv;
    hold_d = out_data; hold_t = out_tag;
`ifdef SHIFTER_ZERO_FLAG_EN
    hold_z = out_zero;
`else
    hold_z = 1'b0;
`endif
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        check_eq("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        check_eq("out_data", 32'(out_data), 32'(e.d));
        check_eq("out_tag", 32'(out_tag), 32'(e.t));
`ifdef SHIFTER_ZERO_FLAG_EN
        check_eq("out_zero", 32'(out_zero), 32'(e.d == '0));
`endif
        if (lat_mode) check_eq("latency", cyc - e.c, SN);
      end
    end
    if (iv && in_ready && !rv) q.push_back('{d: ref_shift(d, sh, m), t: t, c: cyc});
    if (rv) q.delete();
  endtask

  task automatic idle(input logic ordy, input logic rv);
    cycle(1'b0, '0, '0, 3'd0, '0, ordy, rv);
  endtask

  task automatic check_reset();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_tag", 32'(out_tag), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SHIFTER_ZERO_FLAG_EN
    check_eq("rst_out_zero", 32'(out_zero), 32'd0);
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && q.size() != 0; i++) idle(1'b1, 1'b0);
    repeat (SN + 2) idle(1'b1, 1'b0);
    check_eq("drain_empty", q.size(), 0);
  endtask

  task automatic send_rand(input logic ordy);
    cycle(1'b1, DW'($urandom), SN'($urandom), 3'($urandom_range(0, 7)), TW'($urandom), ordy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0; out_ready = 1'b0;
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b0);
    check_reset();

    // Single SRA with latency check; a second valid cycle would show up as spurious.
    lat_mode = 1'b1;
    cycle(1'b1, 16'h8F00, 4'd4, 3'b010, 4'd3, 1'b1, 1'b0);
    drain();

    // Back-to-back mix from the test plan.
    cycle(1'b1, 16'hFFFF, 4'd15, 3'b000, 4'd1, 1'b1, 1'b0);
    cycle(1'b1, 16'h0001, 4'd15, 3'b001, 4'd2, 1'b1, 1'b0);
    cycle(1'b1, 16'h1234, 4'd4,  3'b100, 4'd3, 1'b1, 1'b0);
    cycle(1'b1, 16'h1234, 4'd4,  3'b101, 4'd4, 1'b1, 1'b0);
    drain();

    // shamt=0 on every mode, and rotate wrap-around cases.
    for (int m = 0; m < 8; m++) cycle(1'b1, 16'hA5C3, 4'd0, 3'(m), TW'(m), 1'b1, 1'b0);
    cycle(1'b1, 16'h8001, 4'd15, 3'b100, 4'd9, 1'b1, 1'b0);
    cycle(1'b1, 16'h8001, 4'd15, 3'b101, 4'd10, 1'b1, 1'b0);
    cycle(1'b1, 16'h8000, 4'd15, 3'b010, 4'd11, 1'b1, 1'b0);
    drain();

    // Full-rate random stream.
    for (int i = 0; i < 60; i++) send_rand(1'b1);
    drain();
    lat_mode = 1'b0;

    // Backpressure: fill the pipe, stall, then release.
    for (int i = 0; i < 10; i++) begin
      send_rand(1'b0);
      if (i >= 4) check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    end
    drain();

    // Random valid/ready traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'b1 && ($urandom_range(0, 3) != 0), DW'($urandom), SN'($urandom),
            3'($urandom_range(0, 7)), TW'($urandom), $urandom_range(0, 3) != 0, 1'b0);
    end
    drain();

    // Reset with three ops in flight; a request in the reset cycle is dropped too.
    for (int i = 0; i < 3; i++) send_rand(1'b1);
    cycle(1'b1, 16'h1111, 4'd1, 3'b001, 4'd7, 1'b1, 1'b1);
    idle(1'b0, 1'b0);
    check_reset();
    repeat (SN + 4) idle(1'b1, 1'b0);
    check_eq("post_rst_empty", q.size(), 0);

`ifdef SHIFTER_ZERO_FLAG_EN
    cycle(1'b1, 16'h0008, 4'd4, 3'b000, 4'd5, 1'b1, 1'b0);
    cycle(1'b1, 16'h0010, 4'd4, 3'b000, 4'd6, 1'b1, 1'b0);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
